// File: rtl/mem_wb_pipe_if.sv
// Bundle-side interfaces of the MEM/WB stage.
// mem_wb_in_if : memory stage (master) -> MEM/WB stage (slave)
// mem_wb_out_if: MEM/WB stage (master) -> register-file write ports (slave)

interface mem_wb_in_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 128,
    parameter int RT_W   = 7
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES-1:0]        mem_to_reg_in;
    logic [LANES-1:0]        regwrite_in;
    logic [LANES*DATA_W-1:0] read_data_in;
    logic [LANES*DATA_W-1:0] alu_result_in;
    logic [LANES*RT_W-1:0]   rt_in;

    modport master (
        output in_valid, mem_to_reg_in, regwrite_in, read_data_in, alu_result_in, rt_in,
        input  in_ready
    );

    modport slave (
        input  in_valid, mem_to_reg_in, regwrite_in, read_data_in, alu_result_in, rt_in,
        output in_ready
    );
endinterface

interface mem_wb_out_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 128,
    parameter int RT_W   = 7
);
    logic                    wb_valid;
    logic                    wb_ready;
    logic [LANES-1:0]        wb_we;
    logic [LANES*DATA_W-1:0] wb_data;
    logic [LANES*RT_W-1:0]   wb_rt;

    modport master (
        output wb_valid, wb_we, wb_data, wb_rt,
        input  wb_ready
    );

    modport slave (
        input  wb_valid, wb_we, wb_data, wb_rt,
        output wb_ready
    );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: one held bundle of LANES writeback slots with a
// valid/ready handshake on both sides, flush, same-RT collision resolution
// (highest lane wins) and a saturating count of retired register writes.

module mem_wb_pipe #(
    parameter int LANES  = 2,
    parameter int DATA_W = 128,
    parameter int RT_W   = 7,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,      // active-low, asynchronous
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] retire_count,
    mem_wb_in_if.slave       up,
    mem_wb_out_if.master     wb
);

    logic                    full_q, full_d;
    logic [LANES-1:0]        we_q, we_d;
    logic [LANES-1:0]        m2r_q, m2r_d;
    logic [LANES*DATA_W-1:0] rd_q, rd_d;
    logic [LANES*DATA_W-1:0] alu_q, alu_d;
    logic [LANES*RT_W-1:0]   rt_q, rt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    in_ready_int;
    logic                    capture;
    logic                    retire;
    logic [LANES-1:0]        we_resolved;
    logic [LANES-1:0]        wb_we_int;
    logic [CNT_W:0]          add_cnt;
    logic [CNT_W:0]          sum_cnt;

    // Ready depends only on state and downstream ready, never on in_valid.
    assign in_ready_int = !full_q || wb.wb_ready;
    assign capture      = up.in_valid && in_ready_int && !flush;
    assign retire       = full_q && wb.wb_ready && !flush;
    assign wb_we_int    = {LANES{full_q && !flush}} & we_q;

    assign up.in_ready   = in_ready_int;
    assign wb.wb_valid   = full_q;
    assign wb.wb_we      = wb_we_int;
    assign wb.wb_rt      = rt_q;
    assign retire_count  = cnt_q;

    // Per-lane writeback mux from the stored select, data and ALU registers.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wb.wb_data[gi*DATA_W +: DATA_W] =
                m2r_q[gi] ? rd_q[gi*DATA_W +: DATA_W] : alu_q[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Suppress a lane's write when any younger writing lane targets the same RT.
    always_comb begin
        we_resolved = up.regwrite_in;
        for (int l = 0; l < LANES; l++) begin
            for (int h = 0; h < LANES; h++) begin
                if (h > l && up.regwrite_in[h] &&
                    up.rt_in[h*RT_W +: RT_W] == up.rt_in[l*RT_W +: RT_W]) begin
                    we_resolved[l] = 1'b0;
                end
            end
        end
    end

    // Occupancy and bundle fields: flush empties, capture loads, retire drains.
    always_comb begin
        full_d = full_q;
        we_d   = we_q;
        m2r_d  = m2r_q;
        rd_d   = rd_q;
        alu_d  = alu_q;
        rt_d   = rt_q;
        if (flush) begin
            full_d = 1'b0;
        end else if (capture) begin
            full_d = 1'b1;
            we_d   = we_resolved;
            m2r_d  = up.mem_to_reg_in;
            rd_d   = up.read_data_in;
            alu_d  = up.alu_result_in;
            rt_d   = up.rt_in;
        end else if (retire) begin
            full_d = 1'b0;
        end
    end

    // Saturating retire counter; the carry out of the sum flags overflow.
    always_comb begin
        add_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            add_cnt = add_cnt + {{CNT_W{1'b0}}, wb_we_int[l]};
        end
        sum_cnt = {1'b0, cnt_q} + add_cnt;
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (retire) begin
            cnt_d = sum_cnt[CNT_W] ? {CNT_W{1'b1}} : sum_cnt[CNT_W-1:0];
        end
    end

    // State registers, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            we_q   <= '0;
            m2r_q  <= '0;
            rd_q   <= '0;
            alu_q  <= '0;
            rt_q   <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            we_q   <= we_d;
            m2r_q  <= m2r_d;
            rd_q   <= rd_d;
            alu_q  <= alu_d;
            rt_q   <= rt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: a queue-based bundle model checked
// every negedge, plus hand-computed expectations for each directed scenario.

module tb_mem_wb_pipe;
    localparam int LANES  = 2;
    localparam int DATA_W = 128;
    localparam int RT_W   = 7;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] retire_count;

    mem_wb_in_if  #(.LANES(LANES), .DATA_W(DATA_W), .RT_W(RT_W)) up_if();
    mem_wb_out_if #(.LANES(LANES), .DATA_W(DATA_W), .RT_W(RT_W)) wb_if();

    mem_wb_pipe #(.LANES(LANES), .DATA_W(DATA_W), .RT_W(RT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .cnt_clr      (cnt_clr),
        .retire_count (retire_count),
        .up           (up_if.slave),
        .wb           (wb_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]            we;
        logic [1:0][127:0]     data;
        logic [1:0][6:0]       rt;
    } bundle_t;

    bundle_t exp_q[$];
    int      exp_cnt = 0;
    int      retired_tags[$];
    int      checks = 0;
    int      failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // What a bundle must look like once accepted: resolve RT collisions by
    // walking lanes from youngest down and letting the first claim win.
    function automatic bundle_t resolve_inputs();
        bundle_t    b;
        logic [127:0] claimed;
        logic [6:0] rt;
        b = '0;
        claimed = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            rt = up_if.rt_in[l*RT_W +: RT_W];
            b.rt[l] = rt;
            b.data[l] = up_if.mem_to_reg_in[l] ? up_if.read_data_in[l*DATA_W +: DATA_W]
                                               : up_if.alu_result_in[l*DATA_W +: DATA_W];
            if (up_if.regwrite_in[l]) begin
                b.we[l] = !claimed[rt];
                claimed[rt] = 1'b1;
            end
        end
        return b;
    endfunction

    // Model update on each rising edge.
    initial begin
        bit      ready, ret, cap;
        bundle_t nb;
        int      n;
        forever begin
            @(posedge clk);
            if (!reset) begin
                exp_q.delete();
                exp_cnt = 0;
            end else begin
                ready = (exp_q.size() == 0) || wb_if.wb_ready;
                ret   = (exp_q.size() > 0) && wb_if.wb_ready && !flush;
                cap   = up_if.in_valid && ready && !flush;
                nb    = resolve_inputs();
                if (ret) begin
                    n = $countones(exp_q[0].we);
                    retired_tags.push_back(int'(exp_q[0].data[0][31:0]));
                    $display("retire we=%b rt0=%0d rt1=%0d", exp_q[0].we, exp_q[0].rt[0], exp_q[0].rt[1]);
                end else begin
                    n = 0;
                end
                if (cnt_clr) exp_cnt = 0;
                else if (ret) exp_cnt = (exp_cnt + n > CNT_MAX) ? CNT_MAX : exp_cnt + n;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (ret) void'(exp_q.pop_front());
                    if (cap) begin
                        exp_q.push_back(nb);
                        $display("capture we=%b rt0=%0d rt1=%0d", nb.we, nb.rt[0], nb.rt[1]);
                    end
                end
            end
        end
    end

    // Asynchronous reset empties the model at once.
    initial forever begin
        @(negedge reset);
        exp_q.delete();
        exp_cnt = 0;
    end

    // Compare DUT against the model every falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("rst_valid", wb_if.wb_valid, 0);
            check("rst_we", wb_if.wb_we, 0);
            check("rst_data", wb_if.wb_data, 0);
            check("rst_rt", wb_if.wb_rt, 0);
            check("rst_cnt", retire_count, 0);
        end else begin
            check("cmp_valid", wb_if.wb_valid, exp_q.size() > 0);
            check("cmp_in_ready", up_if.in_ready, (exp_q.size() == 0) || wb_if.wb_ready);
            check("cmp_cnt", retire_count, exp_cnt);
            if (exp_q.size() > 0) begin
                check("cmp_we", wb_if.wb_we, flush ? 2'b00 : exp_q[0].we);
                check("cmp_data", wb_if.wb_data, exp_q[0].data);
                check("cmp_rt", wb_if.wb_rt, exp_q[0].rt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [1:0] m2r, input logic [1:0] rw,
                          input logic [127:0] rd0, input logic [127:0] rd1,
                          input logic [127:0] alu0, input logic [127:0] alu1,
                          input logic [6:0] rt0, input logic [6:0] rt1);
        up_if.in_valid      = v;
        up_if.mem_to_reg_in = m2r;
        up_if.regwrite_in   = rw;
        up_if.read_data_in  = {rd1, rd0};
        up_if.alu_result_in = {alu1, alu0};
        up_if.rt_in         = {rt1, rt0};
    endtask

    initial begin
        wb_if.wb_ready = 1'b0;
        set_in(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // Reset held for two cycles, released between edges.
        step();
        step();
        reset = 1'b1;
        #2;
        check("init_valid", wb_if.wb_valid, 0);
        check("init_cnt", retire_count, 0);
        check("init_in_ready", up_if.in_ready, 1);

        // Basic transfer with per-lane data select.
        wb_if.wb_ready = 1'b1;
        set_in(1, 2'b01, 2'b11, {16{8'hAA}}, 128'hDEAD, {16{8'h55}}, 128'h1234, 7'd5, 7'd9);
        step();
        up_if.in_valid = 1'b0;
        #2;
        check("basic_data0", wb_if.wb_data[127:0], {16{8'hAA}});
        check("basic_data1", wb_if.wb_data[255:128], 128'h1234);
        check("basic_rt0", wb_if.wb_rt[6:0], 7'd5);
        check("basic_rt1", wb_if.wb_rt[13:7], 7'd9);
        check("basic_we", wb_if.wb_we, 2'b11);
        check("basic_cnt_pre", retire_count, 0);
        step();
        #2;
        check("basic_cnt", retire_count, 2);

        // Same-RT collision: younger lane wins; idle lane never suppresses.
        set_in(1, 2'b00, 2'b11, 0, 0, 128'h111, 128'h222, 7'd17, 7'd17);
        step();
        up_if.in_valid = 1'b0;
        #2;
        check("coll_we", wb_if.wb_we, 2'b10);
        check("coll_rt1", wb_if.wb_rt[13:7], 7'd17);
        step();
        #2;
        check("coll_cnt", retire_count, 3);
        set_in(1, 2'b00, 2'b01, 0, 0, 128'h111, 128'h222, 7'd17, 7'd17);
        step();
        up_if.in_valid = 1'b0;
        #2;
        check("coll_we_lane0", wb_if.wb_we, 2'b01);
        step();
        #2;
        check("coll_cnt2", retire_count, 4);

        // Backpressure: three stalled cycles with new data waiting upstream.
        retired_tags.delete();
        wb_if.wb_ready = 1'b0;
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd1, 128'd101, 7'd1, 7'd65);
        step();
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd2, 128'd102, 7'd2, 7'd66);
        for (int i = 0; i < 2; i++) begin
            #2;
            check("bp_in_ready", up_if.in_ready, 0);
            check("bp_hold_data0", wb_if.wb_data[127:0], 128'd1);
            step();
        end
        wb_if.wb_ready = 1'b1;
        step();
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd3, 128'd103, 7'd3, 7'd67);
        step();
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd4, 128'd104, 7'd4, 7'd68);
        step();
        up_if.in_valid = 1'b0;
        step();
        #2;
        check("bp_retired_n", retired_tags.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < retired_tags.size()) check("bp_order", retired_tags[i], i + 1);
        end
        check("bp_cnt", retire_count, 12);

        // Flush of a held bundle while a new one is offered.
        wb_if.wb_ready = 1'b0;
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd5, 128'd105, 7'd5, 7'd69);
        step();
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd6, 128'd106, 7'd6, 7'd70);
        flush = 1'b1;
        wb_if.wb_ready = 1'b1;
        #2;
        check("flush_we", wb_if.wb_we, 2'b00);
        check("flush_valid_pre", wb_if.wb_valid, 1);
        step();
        flush = 1'b0;
        up_if.in_valid = 1'b0;
        #2;
        check("flush_valid", wb_if.wb_valid, 0);
        check("flush_cnt", retire_count, 12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #2;
        check("flush_empty_valid", wb_if.wb_valid, 0);
        check("flush_empty_ready", up_if.in_ready, 1);

        // Counter clear, then saturation at 15.
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        #2;
        check("clr_cnt", retire_count, 0);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 2'b10, 2'b11, 128'(i), 128'(i + 40), 128'(i + 80), 128'(i + 120),
                   7'(i), 7'(i + 20));
            step();
        end
        up_if.in_valid = 1'b0;
        #2;
        check("sat_cnt_14", retire_count, 14);
        step();
        #2;
        check("sat_cnt_15", retire_count, 15);

        // Asynchronous reset while a bundle is held.
        wb_if.wb_ready = 1'b0;
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd7, 128'd107, 7'd7, 7'd71);
        step();
        up_if.in_valid = 1'b0;
        #2;
        check("areset_valid_pre", wb_if.wb_valid, 1);
        reset = 1'b0;
        #1;
        check("areset_valid", wb_if.wb_valid, 0);
        check("areset_we", wb_if.wb_we, 0);
        check("areset_cnt", retire_count, 0);
        step();
        step();
        reset = 1'b1;
        wb_if.wb_ready = 1'b1;
        step();
        step();
        #2;
        check("areset_post_valid", wb_if.wb_valid, 0);
        check("areset_post_cnt", retire_count, 0);

        // cnt_clr wins over an increment in the same cycle.
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd8, 128'd108, 7'd8, 7'd72);
        step();
        set_in(1, 2'b00, 2'b11, 0, 0, 128'd9, 128'd109, 7'd9, 7'd73);
        step();
        up_if.in_valid = 1'b0;
        cnt_clr = 1'b1;
        #2;
        check("clrpri_cnt_pre", retire_count, 2);
        check("clrpri_valid_pre", wb_if.wb_valid, 1);
        step();
        cnt_clr = 1'b0;
        #2;
        check("clrpri_cnt", retire_count, 0);
        check("clrpri_valid", wb_if.wb_valid, 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised MEM/WB pipeline stage for the multi-lane SPU (default: even and odd pipe).
- Holds one bundle of LANES writeback slots, with a valid/ready handshake on both sides, a flush input, same-RT write-collision resolution, and a registered writeback select (memory data vs ALU result).
- Sits between the memory stage and the register-file write ports.
- Keeps a saturating count of retired register writes for performance monitoring.

Parameters:
- LANES, 2, number of parallel writeback lanes (lane 0 = even pipe; higher index = younger/odd).
- DATA_W, 128, writeback data width per lane.
- RT_W, 7, destination register address width (128 registers).
- CNT_W, 32, retired-write counter width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- flush  input  1  kill the held bundle and block capture this cycle.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept a bundle this cycle.
- mem_to_reg_in  input  LANES  per-lane select: 1 = read data, 0 = ALU result.
- regwrite_in  input  LANES  per-lane register write request.
- read_data_in  input  LANES*DATA_W  per-lane memory read data; lane l occupies bits [l*DATA_W +: DATA_W].
- alu_result_in  input  LANES*DATA_W  per-lane ALU result, packed the same way.
- rt_in  input  LANES*RT_W  per-lane destination register, packed the same way.
- wb_valid  output  1  held bundle valid toward the register file.
- wb_ready  input  1  register file accepts the bundle.
- wb_we  output  LANES  per-lane final write enable.
- wb_data  output  LANES*DATA_W  per-lane writeback data.
- wb_rt  output  LANES*RT_W  per-lane destination register.
- cnt_clr  input  1  synchronous clear of retire_count.
- retire_count  output  CNT_W  saturating count of retired lane writes.

Behaviour:
- Reset (reset=0, asynchronous):
  - full=0; all stored fields 0; retire_count=0.
  - Outputs during reset: wb_valid=0, wb_we=0, wb_data=0, wb_rt=0.
  - in_ready=1 whenever reset is deasserted and the stage is empty.
  - Asserting reset mid-bundle discards that bundle; nothing retires.
- Handshake and latency:
  - wb_valid = full.
  - in_ready = !full || wb_ready. No combinational path from in_valid to in_ready.
  - Capture when in_valid && in_ready && !flush. Latency is 1 cycle: fields accepted at edge N appear on the wb_* outputs after edge N.
  - Retire when wb_valid && wb_ready && !flush.
  - Next state of full:
    - flush → 0, with no capture.
    - else capture → 1 (covers simultaneous retire and capture, giving full throughput).
    - else retire → 0.
    - else hold.
  - While full && !wb_ready, every stored field holds stable.
- Collision resolution (computed at capture; stored registered):
  - Lane l's stored write enable = regwrite_in[l] AND NOT (any lane h>l with regwrite_in[h]=1 and rt_in[h]==rt_in[l]).
  - Result: the highest-index lane wins. With 3+ lanes on the same RT, only the top one writes.
  - Lanes with regwrite_in=0 never suppress other lanes.
- Output data:
  - wb_data[l] = stored mem_to_reg[l] ? stored read_data[l] : stored alu_result[l]. Selection is combinational from the stored registers.
  - wb_rt[l] = stored rt[l].
  - wb_we[l] = full && stored_we[l] && !flush. A flushed bundle never presents a write enable.
- Counter:
  - On each retire, add popcount(wb_we) to retire_count, saturating at 2^CNT_W-1 (no wrap).
  - cnt_clr sets retire_count to 0 and has priority over an increment in the same cycle.
- flush is idempotent on an empty stage.
- in_valid while in_ready=0: the upstream holds its data. The stage does not sample it.

Test Plan:
- Reset/basic: reset=0 for 2 cycles, then release; check wb_valid=0, retire_count=0, in_ready=1. Send lane0 {regwrite=1, mem_to_reg=1, rd=0xAA..AA, alu=0x55..55, rt=5}, lane1 {regwrite=1, mem_to_reg=0, alu=0x1234, rt=9}, wb_ready=1. Next cycle: wb_data0=0xAA..AA, wb_rt0=5, wb_data1=0x1234, wb_rt1=9, wb_we=2'b11; after the retire edge, retire_count=2.
- Collision: both lanes regwrite=1 with rt=17 → wb_we=2'b10, wb_rt1=17; retire_count increments by 1. Same bundle with lane1 regwrite=0 → wb_we=2'b01.
- Backpressure: wb_ready=0 for 3 cycles with a new in_valid each cycle → in_ready=0 after the first capture; wb_* hold the first bundle unchanged. Raise wb_ray=1 → first bundle retires and second bundle captured on the same edge; no bundle lost or duplicated (check via scoreboard).
- Flush: held bundle with wb_ready=1, assert flush with in_valid=1 → wb_we=0 in that cycle, full=0 next cycle, retire_count unchanged, new bundle not captured.
- Counter: with CNT_W=4, retire 8 two-write bundles → retire_count saturates at 15. Assert cnt_clr together with a retire → retire_count=0.
- Async reset mid-operation: assert reset=0 between clock edges while full → wb_valid falls immediately without waiting for a clock; no retire_count change after release.
